// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline control sequencer
package pipe_ctrl_pkg;

  localparam int REG_IDX_W  = 5;
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    HOLD   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } ctrl_state_e;

  // One bundle of the four pipeline control strobes
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_out_t;

  // Reset/hold pattern: fetch frozen, both pipeline registers cleared
  function automatic ctrl_out_t hold_out();
    ctrl_out_t o;
    o.pc_en       = 1'b0;
    o.if_id_en    = 1'b1;
    o.if_id_flush = 1'b1;
    o.id_ex_flush = 1'b1;
    return o;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between EX load and ID sources
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  output logic                 load_use
);

  logic dest_live;
  logic rs_hit;
  logic rt_hit;

  // $zero is never a real dependency, so a load targeting r0 cannot stall
  assign dest_live = ex_mem_read && (ex_rt != '0);
  assign rs_hit    = (ex_rt == id_rs);
  assign rt_hit    = id_uses_rt && (ex_rt == id_rt);
  assign load_use  = dest_live && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline control FSM (HOLD/RUN/SQUASH); optional HAZARD_CTRL_PERF_EN adds stall/squash counters
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RESET_HOLD = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rt,
  input  logic                 branch_taken,
  input  logic                 imem_ready,
  output logic                 pc_en,
  output logic                 IF_ID_en,
  output logic                 IF_ID_flush,
  output logic                 ID_EX_flush
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          squash_cnt
`endif
);

  localparam logic [HOLD_CNT_W-1:0] HOLD_INIT = HOLD_CNT_W'(RESET_HOLD - 1);

  ctrl_state_e             state;
  ctrl_state_e             state_nxt;
  logic [HOLD_CNT_W-1:0]   hold_cnt;
  logic [HOLD_CNT_W-1:0]   hold_cnt_nxt;
  logic                    load_use;
  ctrl_out_t               ctl;

  load_use_detect u_load_use_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  // State and hold counter registers; reset re-arms the hold-off window
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= HOLD;
      hold_cnt <= HOLD_INIT;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Next state and control strobes; reset forces the hold pattern regardless of state
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    ctl          = hold_out();
    if (!rst) begin
      unique case (state)
        HOLD: begin
          if (hold_cnt == '0) begin
            state_nxt = RUN;
          end else begin
            hold_cnt_nxt = hold_cnt - 1'b1;
          end
        end
        RUN: begin
          if (load_use) begin
            // Branch operands are stale during a load-use stall; it re-resolves next cycle
            ctl.pc_en       = 1'b0;
            ctl.if_id_en    = 1'b0;
            ctl.if_id_flush = 1'b0;
            ctl.id_ex_flush = 1'b1;
          end else if (branch_taken) begin
            ctl.pc_en       = 1'b1;
            ctl.if_id_en    = 1'b1;
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b0;
            // PC takes the target now, but the old-PC fetch is still outstanding
            if (!imem_ready) begin
              state_nxt = SQUASH;
            end
          end else if (!imem_ready) begin
            ctl.pc_en       = 1'b0;
            ctl.if_id_en    = 1'b1;
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b0;
          end else begin
            ctl.pc_en       = 1'b1;
            ctl.if_id_en    = 1'b1;
            ctl.if_id_flush = 1'b0;
            ctl.id_ex_flush = 1'b0;
          end
        end
        SQUASH: begin
          // ID holds a bubble, so hazards are irrelevant; drop the wrong-path word on return
          ctl.pc_en       = 1'b0;
          ctl.if_id_en    = 1'b1;
          ctl.if_id_flush = 1'b1;
          ctl.id_ex_flush = 1'b0;
          if (imem_ready) begin
            state_nxt = RUN;
          end
        end
        default: begin
          state_nxt    = HOLD;
          hold_cnt_nxt = HOLD_INIT;
        end
      endcase
    end
  end

  assign pc_en       = ctl.pc_en;
  assign IF_ID_en    = ctl.if_id_en;
  assign IF_ID_flush = ctl.if_id_flush;
  assign ID_EX_flush = ctl.id_ex_flush;

`ifdef HAZARD_CTRL_PERF_EN
  // Free-running event counters: frozen-PC cycles in RUN and flushed IF/ID slots outside HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (state == RUN && !ctl.pc_en) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (state != HOLD && ctl.if_id_flush) begin
        squash_cnt <= squash_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed and randomized check of hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

  localparam int RH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_mem_read;
  logic [4:0] ex_rt;
  logic       branch_taken;
  logic       imem_ready;
  logic       pc_en;
  logic       IF_ID_en;
  logic       IF_ID_flush;
  logic       ID_EX_flush;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] squash_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Model: remaining hold cycles and whether a wrong-path fetch is outstanding
  int          m_hold   = RH;
  bit          m_squash = 1'b0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_sqcnt  = '0;
  bit          m_perf_ok = 1'b0;

  hazard_ctrl #(.RESET_HOLD(RH)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_taken (branch_taken),
    .imem_ready   (imem_ready),
    .pc_en        (pc_en),
    .IF_ID_en     (IF_ID_en),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_flush  (ID_EX_flush)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .squash_cnt   (squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model across the edge
  task automatic step(input string tag, input logic r, input logic bt, input logic ir,
                      input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt);
    logic [3:0] exp;
    bit lu;
    bit in_hold;
    bit in_sq;
    rst = r; branch_taken = bt; imem_ready = ir; ex_mem_read = mr;
    ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    @(negedge clk);
    lu      = mr && (ert != 0) && (ert == rs || (urt && ert == rt));
    in_hold = r || (m_hold > 0);
    in_sq   = !in_hold && m_squash;
    if (in_hold)        exp = 4'b0111;
    else if (in_sq)     exp = 4'b0110;
    else if (lu)        exp = 4'b0001;
    else if (bt)        exp = 4'b1110;
    else if (!ir)       exp = 4'b0110;
    else                exp = 4'b1100;
    check_vec(tag, {28'd0, pc_en, IF_ID_en, IF_ID_flush, ID_EX_flush}, {28'd0, exp});
`ifdef HAZARD_CTRL_PERF_EN
    if (m_perf_ok) begin
      check_vec({tag, "_stallcnt"}, stall_cnt, m_stall);
      check_vec({tag, "_squashcnt"}, squash_cnt, m_sqcnt);
    end
`endif
    if (r) begin
      m_hold = RH; m_squash = 1'b0; m_stall = '0; m_sqcnt = '0; m_perf_ok = 1'b1;
    end else begin
      if (!in_hold && !in_sq && !exp[3]) m_stall = m_stall + 1;
      if (!in_hold && exp[1])            m_sqcnt = m_sqcnt + 1;
      if (m_hold > 0)                    m_hold--;
      else if (in_sq && ir)              m_squash = 1'b0;
      else if (!in_sq && !lu && bt && !ir) m_squash = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // tag, rst, branch_taken, imem_ready, ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt
    step("reset",        1, 0, 1, 0, 0, 0, 0, 0);
    step("hold1",        0, 0, 1, 0, 0, 0, 0, 0);
    step("hold2",        0, 0, 1, 0, 0, 0, 0, 0);
    step("first_run",    0, 0, 1, 0, 0, 0, 0, 0);
    step("lu_rs",        0, 0, 1, 1, 8, 8, 0, 0);
    step("lu_after",     0, 0, 1, 0, 8, 8, 0, 0);
    step("lu_r0",        0, 0, 1, 1, 0, 0, 0, 0);
    step("rt_unused",    0, 0, 1, 1, 9, 1, 9, 0);
    step("rt_used",      0, 0, 1, 1, 9, 1, 9, 1);
    step("br_ready",     0, 1, 1, 0, 0, 0, 0, 0);
    step("br_ready_nx",  0, 0, 1, 0, 0, 0, 0, 0);
    step("br_wait",      0, 1, 0, 0, 0, 0, 0, 0);
    step("sq_wait1",     0, 0, 0, 0, 0, 0, 0, 0);
    step("sq_wait2",     0, 1, 0, 1, 4, 4, 0, 0);
    step("sq_ready",     0, 0, 1, 0, 0, 0, 0, 0);
    step("sq_target",    0, 0, 1, 0, 0, 0, 0, 0);
    step("lu_and_br",    0, 1, 1, 1, 8, 8, 0, 0);
    step("br_after_lu",  0, 1, 1, 0, 8, 8, 0, 0);
    step("after_br",     0, 0, 1, 0, 0, 0, 0, 0);
    step("fetch_wait",   0, 0, 0, 0, 0, 0, 0, 0);
    step("br_wait_b",    0, 1, 0, 0, 0, 0, 0, 0);
    step("sq_quick",     0, 0, 1, 0, 0, 0, 0, 0);
    step("run_quick",    0, 0, 1, 0, 0, 0, 0, 0);
    step("br_wait_c",    0, 1, 0, 0, 0, 0, 0, 0);
    step("rst_in_sq",    1, 0, 0, 0, 0, 0, 0, 0);
    step("hold_a",       0, 1, 0, 1, 3, 3, 0, 0);
    step("hold_b",       0, 0, 1, 0, 0, 0, 0, 0);
    step("run_again",    0, 0, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      step("rand",
           ($urandom % 60) == 0,
           ($urandom % 4) == 0,
           ($urandom % 3) != 0,
           $urandom % 2,
           5'($urandom % 4),
           5'($urandom % 4),
           5'($urandom % 4),
           $urandom % 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control sequencer for the five-stage MIPS core. Each cycle it drives the PC load enable, the IF/ID register enable and flush, and the ID/EX bubble. It covers reset hold-off, load-use stalls, taken-branch/jump squashes and multi-cycle instruction-fetch waits. It also tracks a wrong-path fetch that is still in flight after a redirect and discards it when it returns.

## Interface
Parameters:
- `RESET_HOLD`, default 2: cycles after reset during which fetch is held and the pipeline is flushed; legal range 1..15.

Ports:
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `id_rs`  in  5  rs field of the instruction in ID
- `id_rt`  in  5  rt field of the instruction in ID
- `id_uses_rt`  in  1  ID instruction reads rt as a source
- `ex_mem_read`  in  1  instruction in EX is a load
- `ex_rt`  in  5  destination register of the load in EX
- `branch_taken`  in  1  branch or jump resolved taken in ID this cycle
- `imem_ready`  in  1  the fetch for the current PC completes this cycle
- `pc_en`  out  1  PC register load enable
- `IF_ID_en`  out  1  IF/ID load enable
- `IF_ID_flush`  out  1  IF/ID synchronous clear (takes priority over the enable)
- `ID_EX_flush`  out  1  insert a bubble into ID/EX

## Operation
- FSM states: `HOLD`, `RUN`, `SQUASH`. Outputs are combinational from the state and the current inputs. State and counter are registered.
- `load_use`: `ex_mem_read && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt))`.
- `HOLD` outputs:
  - `pc_en`=0, `IF_ID_en`=1, `IF_ID_flush`=1, `ID_EX_flush`=1.
  - A down-counter is loaded with `RESET_HOLD-1` on reset. Go to `RUN` in the cycle the counter reads 0.
- `RUN`: evaluate in strict priority, first match wins.
  1. `load_use`: `pc_en`=0, `IF_ID_en`=0, `IF_ID_flush`=0, `ID_EX_flush`=1. `branch_taken` is ignored, because its operands are stale; the branch re-resolves next cycle.
  2. `branch_taken && imem_ready`: `pc_en`=1, `IF_ID_en`=1, `IF_ID_flush`=1, `ID_EX_flush`=0. Stay in `RUN`.
  3. `branch_taken && !imem_ready`: same outputs as rule 2, go to `SQUASH`. PC captures the target; the in-flight fetch of the old PC cannot be cancelled.
  4. `!imem_ready`: `pc_en`=0, `IF_ID_en`=1, `IF_ID_flush`=1 (bubble into ID), `ID_EX_flush`=0.
  5. Otherwise: `pc_en`=1, `IF_ID_en`=1, both flushes 0.
- `SQUASH`:
  - `pc_en`=0, `IF_ID_en`=1, `IF_ID_flush`=1, `ID_EX_flush`=0.
  - `load_use` and `branch_taken` are ignored, because ID holds a bubble.
  - When `imem_ready`=1, the returned wrong-path word is flushed that same cycle and the FSM goes to `RUN`. The next cycle fetches the target.

## Timing
- Reset: `rst` sampled high puts the FSM in `HOLD` with the counter at `RESET_HOLD-1`.
  - Outputs during reset and `HOLD`: `pc_en`=0, `IF_ID_en`=1, `IF_ID_flush`=1, `ID_EX_flush`=1.
  - `rst` mid-`SQUASH` or mid-stall aborts immediately to `HOLD`; nothing pending survives.
- First `pc_en`=1 is exactly `RESET_HOLD` cycles after the reset edge is released.
- Load-use stall: one cycle when the load advances normally. It repeats while the condition holds; no counting is needed.
- Branch penalty: one flushed slot if `imem_ready`=1. Otherwise 1 + N + 1 cycles, where N is the number of not-ready cycles in `SQUASH`.
- `imem_ready` already high on the first `SQUASH` cycle: one `SQUASH` cycle, then `RUN`.

## Configuration
- `HAZARD_CTRL_PERF_EN` defined: adds outputs `stall_cnt` [31:0] and `squash_cnt` [31:0].
  - `stall_cnt` increments on every `RUN` cycle with `pc_en`=0.
  - `squash_cnt` increments on every cycle with `IF_ID_flush`=1 outside `HOLD`.
  - Both clear on `rst` and wrap modulo 2^32.
- Not defined: the ports and logic are absent; control behaviour is identical.

## Structure
- Shared package `pipe_ctrl_pkg`: state enum (`HOLD`, `RUN`, `SQUASH`) and `REG_IDX_W`=5.
- Sub-module `load_use_detect`: combinational compare producing `load_use`. The FSM, hold counter and perf counters live in `hazard_ctrl`.

## Test plan
- `RESET_HOLD`=2, `rst` for 1 cycle then released → 2 cycles with `pc_en`=0, `IF_ID_flush`=1, `ID_EX_flush`=1; third cycle `pc_en`=1, flushes 0.
- `ex_mem_read`=1, `ex_rt`=8, `id_rs`=8 → one cycle of `pc_en`=0, `IF_ID_en`=0, `ID_EX_flush`=1; next cycle (`ex_mem_read`=0) normal. Repeat with `ex_rt`=0 → no stall.
- `id_rt`=9, `ex_rt`=9, `id_uses_rt`=0 → no stall; with `id_uses_rt`=1 → stall.
- `branch_taken`=1, `imem_ready`=1 → `pc_en`=1, `IF_ID_flush`=1 for one cycle, FSM stays in `RUN`.
- `branch_taken`=1, `imem_ready`=0, ready returns 3 cycles later → 1 redirect cycle, then 3 cycles of `pc_en`=0 with `IF_ID_flush`=1 (the last of these is the ready cycle), then `pc_en`=1 in `RUN`.
- `load_use`=1 and `branch_taken`=1 together → stall outputs only, `IF_ID_flush`=0; the branch taken next cycle then flushes. With `HAZARD_CTRL_PERF_EN` defined, `stall_cnt`=1 and `squash_cnt`=1 afterwards.
